exp_norm_decrement: RTL and testbench

- Sequential left-normalization stage for the FP add/subtract datapath. It is the inverse of the multiplier's exponent-increment/overflow phase.
- Takes an unnormalized significand and a partial exponent. Each cycle it shifts the significand left by one bit and decrements the exponent, until the MSB is 1.
- Flags underflow when the exponent would drop below 1, and flags an all-zero significand.
- Sits between the significand add/sub phase and the rounding phase.

---
 rtl/exp_norm_decrement.sv | 130 +++++++++++++
 tb/tb_exp_norm_decrement.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/exp_norm_decrement.sv
// Sequential left-normalization stage for the FP add/subtract datapath.
// Optional feature: define NORM_FAST_SHIFT_EN to allow two-bit shift steps.
module exp_norm_decrement #(
    parameter int W_Exp = 8,
    parameter int W_Sgf = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [W_Exp-1:0] exp_in,
    input  logic [W_Sgf-1:0] sgf_in,
    output logic             busy,
    output logic             done,
    output logic [W_Exp-1:0] exp_out,
    output logic [W_Sgf-1:0] sgf_out,
    output logic             underflow_b,
    output logic             zero_flag
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [W_Exp-1:0] EXP_ONE = W_Exp'(1);
`ifdef NORM_FAST_SHIFT_EN
    localparam logic [W_Exp-1:0] EXP_TWO   = W_Exp'(2);
    localparam logic [W_Exp-1:0] EXP_THREE = W_Exp'(3);
`endif

    state_t             state, state_next;
    logic [W_Exp-1:0]   exp_reg, exp_reg_next;
    logic [W_Sgf-1:0]   sgf_reg, sgf_reg_next;
    logic [W_Exp-1:0]   exp_out_next;
    logic [W_Sgf-1:0]   sgf_out_next;
    logic               underflow_next;
    logic               zero_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Priority inside SHIFT: zero, already normalized, exponent floor, shift.
    always_comb begin
        state_next     = state;
        exp_reg_next   = exp_reg;
        sgf_reg_next   = sgf_reg;
        exp_out_next   = exp_out;
        sgf_out_next   = sgf_out;
        underflow_next = underflow_b;
        zero_next      = zero_flag;

        case (state)
            IDLE: begin
                if (start) begin
                    exp_reg_next = exp_in;
                    sgf_reg_next = sgf_in;
                    state_next   = SHIFT;
                end
            end
            SHIFT: begin
                if (sgf_reg == '0) begin
                    exp_out_next   = '0;
                    sgf_out_next   = '0;
                    zero_next      = 1'b1;
                    underflow_next = 1'b0;
                    state_next     = DONE;
                end else if (sgf_reg[W_Sgf-1]) begin
                    exp_out_next   = exp_reg;
                    sgf_out_next   = sgf_reg;
                    zero_next      = 1'b0;
                    underflow_next = 1'b0;
                    state_next     = DONE;
                end else if (exp_reg <= EXP_ONE) begin
                    exp_out_next   = exp_reg;
                    sgf_out_next   = sgf_reg;
                    zero_next      = 1'b0;
                    underflow_next = 1'b1;
                    state_next     = DONE;
                end else begin
`ifdef NORM_FAST_SHIFT_EN
                    if (!sgf_reg[W_Sgf-2] && (exp_reg >= EXP_THREE)) begin
                        sgf_reg_next = {sgf_reg[W_Sgf-3:0], 2'b00};
                        exp_reg_next = exp_reg - EXP_TWO;
                    end else begin
                        sgf_reg_next = {sgf_reg[W_Sgf-2:0], 1'b0};
                        exp_reg_next = exp_reg - EXP_ONE;
                    end
`else
                    sgf_reg_next = {sgf_reg[W_Sgf-2:0], 1'b0};
                    exp_reg_next = exp_reg - EXP_ONE;
`endif
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exp_reg     <= '0;
            sgf_reg     <= '0;
            exp_out     <= '0;
            sgf_out     <= '0;
            underflow_b <= 1'b0;
            zero_flag   <= 1'b0;
        end else begin
            exp_reg     <= exp_reg_next;
            sgf_reg     <= sgf_reg_next;
            exp_out     <= exp_out_next;
            sgf_out     <= sgf_out_next;
            underflow_b <= underflow_next;
            zero_flag   <= zero_next;
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_exp_norm_decrement.sv
// Randomized self-checking bench for exp_norm_decrement against a
// leading-zero-count reference model.
module tb_exp_norm_decrement;

    localparam int W_Exp = 8;
    localparam int W_Sgf = 24;
    localparam int MAX_CYC = 200;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [W_Exp-1:0] exp_in = '0;
    logic [W_Sgf-1:0] sgf_in = '0;
    logic             busy;
    logic             done;
    logic [W_Exp-1:0] exp_out;
    logic [W_Sgf-1:0] sgf_out;
    logic             underflow_b;
    logic             zero_flag;

    int vectors = 0;
    int miscompares = 0;

    exp_norm_decrement #(.W_Exp(W_Exp), .W_Sgf(W_Sgf)) dut (
        .clk(clk), .rst(rst), .start(start), .exp_in(exp_in), .sgf_in(sgf_in),
        .busy(busy), .done(done), .exp_out(exp_out), .sgf_out(sgf_out),
        .underflow_b(underflow_b), .zero_flag(zero_flag)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Result follows from the leading-zero count and how far the exponent may fall.
    function automatic void refModel(input logic [W_Exp-1:0] e, input logic [W_Sgf-1:0] s,
                                     output logic [W_Exp-1:0] eo, output logic [W_Sgf-1:0] so,
                                     output logic uf, output logic zf, output int n);
        int lz, room, k, rem, ev;
        eo = '0; so = '0; uf = 1'b0; zf = 1'b0; n = 0;
        if (s == '0) begin
            zf = 1'b1;
            return;
        end
        lz = 0;
        while (s[W_Sgf-1-lz] == 1'b0) lz++;
        room = (int'(e) >= 1) ? int'(e) - 1 : 0;
        k = (lz <= room) ? lz : room;
        uf = (lz > room);
        eo = W_Exp'(int'(e) - k);
        so = s << k;
`ifdef NORM_FAST_SHIFT_EN
        rem = lz;
        ev = int'(e);
        while (rem > 0 && ev > 1) begin
            if (rem >= 2 && ev >= 3) begin
                rem -= 2; ev -= 2;
            end else begin
                rem -= 1; ev -= 1;
            end
            n++;
        end
`else
        rem = 0;
        ev = 0;
        n = k;
`endif
    endfunction

    // Runs one operation; poke_at re-pulses start mid-run, abort_at asserts reset.
    task automatic applyStimulus(input logic [W_Exp-1:0] e, input logic [W_Sgf-1:0] s,
                                 input int poke_at, input int abort_at, output int cycles);
        @(negedge clk);
        exp_in = e; sgf_in = s; start = 1'b1;
        @(posedge clk);
        cycles = 1;
        #1 start = 1'b0;
        exp_in = W_Exp'($urandom);
        sgf_in = W_Sgf'($urandom);
        while (!done && cycles < MAX_CYC) begin
            if (cycles == poke_at) begin
                @(negedge clk);
                start = 1'b1; exp_in = 8'h10; sgf_in = 24'h800000;
                @(posedge clk);
                cycles++;
                #1 start = 1'b0;
            end else begin
                @(posedge clk);
                cycles++;
                #1;
            end
            if (cycles == abort_at) begin
                #1 rst = 1'b0;
                #1;
                checkOutput("abort_busy", busy, 0);
                checkOutput("abort_done", done, 0);
                checkOutput("abort_exp", exp_out, 0);
                checkOutput("abort_sgf", sgf_out, 0);
                checkOutput("abort_uf", underflow_b, 0);
                checkOutput("abort_zf", zero_flag, 0);
                repeat (3) begin
                    @(posedge clk);
                    #1 checkOutput("abort_nodone", done, 0);
                end
                @(negedge clk) rst = 1'b1;
                @(posedge clk);
                #1 checkOutput("abort_idle", busy, 0);
                cycles = -1;
                return;
            end
        end
    endtask

    task automatic runAndCheck(input string tag, input logic [W_Exp-1:0] e, input logic [W_Sgf-1:0] s,
                               input int poke_at);
        logic [W_Exp-1:0] eo;
        logic [W_Sgf-1:0] so;
        logic uf, zf;
        int n, cycles;
        refModel(e, s, eo, so, uf, zf, n);
        applyStimulus(e, s, poke_at, -1, cycles);
        checkOutput({tag, "_done"}, done, 1);
        checkOutput({tag, "_busy"}, busy, 1);
        checkOutput({tag, "_lat"}, 64'(cycles), 64'(n + 2));
        checkOutput({tag, "_exp"}, exp_out, eo);
        checkOutput({tag, "_sgf"}, sgf_out, so);
        checkOutput({tag, "_uf"}, underflow_b, uf);
        checkOutput({tag, "_zf"}, zero_flag, zf);
        @(posedge clk);
        #1 checkOutput({tag, "_pulse"}, done, 0);
        checkOutput({tag, "_hold"}, exp_out, eo);
    endtask

    initial begin
        int cyc;
        logic [W_Exp-1:0] re;
        logic [W_Sgf-1:0] rs;

        #2;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_exp", exp_out, 0);
        checkOutput("rst_sgf", sgf_out, 0);
        checkOutput("rst_uf", underflow_b, 0);
        checkOutput("rst_zf", zero_flag, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        runAndCheck("norm", 8'h80, 24'h800000, -1);
        runAndCheck("lsb", 8'h80, 24'h000001, -1);
        runAndCheck("uflow", 8'h03, 24'h100000, -1);
        runAndCheck("zero", 8'h7F, 24'h000000, -1);
        runAndCheck("exp0", 8'h00, 24'h400000, -1);
        runAndCheck("exp1n", 8'h01, 24'h800000, -1);
        runAndCheck("ignore", 8'h80, 24'h000001, 5);

        applyStimulus(8'h80, 24'h000001, -1, 10, cyc);
        checkOutput("abort_ret", 64'(cyc), 64'hFFFF_FFFF_FFFF_FFFF);
        runAndCheck("post", 8'h80, 24'h000001, -1);

        // Start held high: one IDLE cycle between back-to-back operations.
        @(negedge clk);
        exp_in = 8'h80; sgf_in = 24'h800000; start = 1'b1;
        cyc = 0;
        while (!done && cyc < MAX_CYC) begin
            @(posedge clk);
            cyc++;
            #1;
        end
        checkOutput("b2b_done", done, 1);
        @(posedge clk);
        #1 checkOutput("b2b_gap", busy, 0);
        @(posedge clk);
        #1 checkOutput("b2b_accept", busy, 1);
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < MAX_CYC) begin
            @(posedge clk);
            cyc++;
            #1;
        end
        checkOutput("b2b_done2", done, 1);
        checkOutput("b2b_exp", exp_out, 8'h80);
        @(posedge clk);

        for (int i = 0; i < 150; i++) begin
            re = ($urandom_range(0, 3) == 0) ? W_Exp'($urandom_range(0, 30)) : W_Exp'($urandom);
            rs = W_Sgf'($urandom) >> $urandom_range(0, W_Sgf);
            runAndCheck("rand", re, rs, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
